// File: rtl/cp0_pkg.sv
// CP0 register numbers, field positions and exception codes
// shared by the Status/Cause/EPC block and its sub-modules.
package cp0_pkg;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  // Status field positions
  localparam int unsigned ST_BEV    = 22;
  localparam int unsigned ST_IM_LSB = 8;
  localparam int unsigned ST_ERL    = 2;
  localparam int unsigned ST_EXL    = 1;
  localparam int unsigned ST_IE     = 0;

  // Cause field positions
  localparam int unsigned CA_BD      = 31;
  localparam int unsigned CA_IP_LSB  = 8;
  localparam int unsigned CA_EXC_LSB = 2;

  // ExcCode values
  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;
  localparam logic [4:0] EXC_RI  = 5'd10;
  localparam logic [4:0] EXC_OV  = 5'd12;

  function automatic logic [31:0] pack_status(
    input logic       bev,
    input logic [7:0] im,
    input logic       erl,
    input logic       exl,
    input logic       ie
  );
    return {9'b0, bev, 6'b0, im, 5'b0, erl, exl, ie};
  endfunction

  function automatic logic [31:0] pack_cause(
    input logic       bd,
    input logic [7:0] ip,
    input logic [4:0] code
  );
    return {bd, 15'b0, ip, 1'b0, code, 2'b0};
  endfunction

endpackage

// File: rtl/cp0_int_pending.sv
// Cause.IP register: software bits written by MTC0, hardware
// bits sampled every cycle; produces the masked interrupt request.
module cp0_int_pending
  import cp0_pkg::*;
#(
  parameter int unsigned NUM_HW_INT = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_HW_INT-1:0] hw_int,
  input  logic                  sw_we,
  input  logic [1:0]            sw_wdata,
  input  logic [7:0]            im,
  input  logic                  ie,
  input  logic                  exl,
  input  logic                  erl,
  output logic [7:0]            ip,
  output logic                  int_req
);

  logic [1:0]            ip_sw_q;
  logic [1:0]            ip_sw_d;
  logic [NUM_HW_INT-1:0] ip_hw_q;

  // Software pending bits change only on a qualified Cause write
  always_comb begin
    ip_sw_d = ip_sw_q;
    if (sw_we) begin
      ip_sw_d = sw_wdata;
    end
  end

  // Register both halves; hardware lines are sampled unconditionally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ip_sw_q <= 2'b0;
      ip_hw_q <= '0;
    end else begin
      ip_sw_q <= ip_sw_d;
      ip_hw_q <= hw_int;
    end
  end

  // Assemble IP with unused upper lines tied to zero
  always_comb begin
    ip                       = 8'h00;
    ip[1:0]                  = ip_sw_q;
    ip[2+NUM_HW_INT-1:2]     = ip_hw_q;
  end

  assign int_req = ie & ~exl & ~erl & (|(ip & im));

endmodule

// File: rtl/cp0_status_cause.sv
// CP0 Status (12), Cause (13) and EPC (14) with interrupt
// latching, exception entry and ERET sequencing.
module cp0_status_cause
  import cp0_pkg::*;
#(
  parameter int unsigned NUM_HW_INT = 6,
  parameter logic        RESET_BEV  = 1'b0,
  parameter logic [7:0]  RESET_IM   = 8'hFF,
  parameter logic        RESET_IE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [4:0]            waddr,
  input  logic [31:0]           wdata,
  input  logic [4:0]            raddr,
  output logic [31:0]           rdata,
  input  logic [NUM_HW_INT-1:0] hw_int,
  input  logic                  exc_req,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_pc,
  input  logic                  exc_bd,
  input  logic                  eret,
  output logic                  int_req,
  output logic [31:0]           epc_out,
  output logic                  exl_out,
  output logic                  bev_out
);

  logic        bev_q, bev_d;
  logic [7:0]  im_q, im_d;
  logic        erl_q, erl_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d;
  logic [7:0]  ip;
  logic        mtc0_ok;
  logic        cause_we;

  // An MTC0 only lands when no exception or ERET claims the cycle
  assign mtc0_ok  = we & ~exc_req & ~eret;
  assign cause_we = mtc0_ok & (waddr == CP0_CAUSE);

  cp0_int_pending #(
    .NUM_HW_INT (NUM_HW_INT)
  ) u_int_pending (
    .clk      (clk),
    .rst      (rst),
    .hw_int   (hw_int),
    .sw_we    (cause_we),
    .sw_wdata (wdata[9:8]),
    .im       (im_q),
    .ie       (ie_q),
    .exl      (exl_q),
    .erl      (erl_q),
    .ip       (ip),
    .int_req  (int_req)
  );

  // Next state: exception entry beats ERET, which beats MTC0
  always_comb begin
    bev_d  = bev_q;
    im_d   = im_q;
    erl_d  = erl_q;
    exl_d  = exl_q;
    ie_d   = ie_q;
    bd_d   = bd_q;
    code_d = code_q;
    epc_d  = epc_q;
    if (exc_req) begin
      exl_d  = 1'b1;
      code_d = exc_code;
      if (!exl_q) begin
        bd_d  = exc_bd;
        epc_d = exc_bd ? (exc_pc - 32'd4) : exc_pc;
      end
    end else if (eret) begin
      if (erl_q) begin
        erl_d = 1'b0;
      end else begin
        exl_d = 1'b0;
      end
    end else if (we) begin
      case (waddr)
        CP0_STATUS: begin
          bev_d = wdata[ST_BEV];
          im_d  = wdata[ST_IM_LSB +: 8];
          erl_d = wdata[ST_ERL];
          exl_d = wdata[ST_EXL];
          ie_d  = wdata[ST_IE];
        end
        CP0_EPC: begin
          epc_d = wdata;
        end
        default: begin
        end
      endcase
    end
  end

  // Architectural state with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bev_q  <= RESET_BEV;
      im_q   <= RESET_IM;
      erl_q  <= 1'b0;
      exl_q  <= 1'b0;
      ie_q   <= RESET_IE;
      bd_q   <= 1'b0;
      code_q <= 5'd0;
      epc_q  <= 32'd0;
    end else begin
      bev_q  <= bev_d;
      im_q   <= im_d;
      erl_q  <= erl_d;
      exl_q  <= exl_d;
      ie_q   <= ie_d;
      bd_q   <= bd_d;
      code_q <= code_d;
      epc_q  <= epc_d;
    end
  end

  // MFC0 read mux; unknown register numbers read as zero
  always_comb begin
    rdata = 32'd0;
    case (raddr)
      CP0_STATUS: rdata = pack_status(bev_q, im_q, erl_q, exl_q, ie_q);
      CP0_CAUSE:  rdata = pack_cause(bd_q, ip, code_q);
      CP0_EPC:    rdata = epc_q;
      default:    rdata = 32'd0;
    endcase
  end

  assign epc_out = epc_q;
  assign exl_out = exl_q;
  assign bev_out = bev_q;

endmodule

// File: tb/tb_cp0_status_cause.sv
// Directed bench for cp0_status_cause: reset, MTC0/MFC0,
// interrupt latching, exception entry, ERET and priorities.
module tb_cp0_status_cause;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr;
  logic [31:0] rdata;
  logic [5:0]  hw_int;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        eret;
  logic        int_req;
  logic [31:0] epc_out;
  logic        exl_out;
  logic        bev_out;

  int n_cmp;
  int n_err;

  cp0_status_cause #(
    .NUM_HW_INT (6),
    .RESET_BEV  (1'b0),
    .RESET_IM   (8'hFF),
    .RESET_IE   (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr    (raddr),
    .rdata    (rdata),
    .hw_int   (hw_int),
    .exc_req  (exc_req),
    .exc_code (exc_code),
    .exc_pc   (exc_pc),
    .exc_bd   (exc_bd),
    .eret     (eret),
    .int_req  (int_req),
    .epc_out  (epc_out),
    .exl_out  (exl_out),
    .bev_out  (bev_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [4:0] a,
                    input logic [31:0] exp);
    raddr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    we = 0; exc_req = 0; eret = 0;
    waddr = 0; wdata = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1; waddr = a; wdata = d;
    step();
    idle();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 0; raddr = 0; hw_int = 0;
    exc_code = 0; exc_pc = 0; exc_bd = 0;
    idle();

    // reset with clock not yet toggled
    #1 rst = 1;
    #1;
    rd("rst_status", 5'd12, 32'h0000_FF01);
    chk("rst_intreq", {31'b0, int_req}, 32'd0);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_epc", 5'd14, 32'h0);
    rd("rst_other", 5'd3, 32'h0);
    @(negedge clk);
    step();
    rst = 0;
    step();

    // status write; not forwarded in the same cycle
    we = 1; waddr = 5'd12; wdata = 32'h0040_0403;
    rd("nofwd", 5'd12, 32'h0000_FF01);
    step();
    idle();
    rd("st_wr", 5'd12, 32'h0040_0403);
    chk("bev", {31'b0, bev_out}, 32'd1);
    chk("exl", {31'b0, exl_out}, 32'd1);
    wr(5'd13, 32'hFFFF_FFFF);
    rd("cause_sw", 5'd13, 32'h0000_0300);
    chk("ireq_exl", {31'b0, int_req}, 32'd0);
    wr(5'd13, 32'h0);
    rd("cause_clr", 5'd13, 32'h0);
    wr(5'd7, 32'hFFFF_FFFF);
    rd("ign_wr", 5'd12, 32'h0040_0403);

    // hardware interrupt latency and masking
    wr(5'd12, 32'h0000_0401);
    hw_int = 6'b000001;
    #1;
    chk("ireq_pre", {31'b0, int_req}, 32'd0);
    step();
    chk("ireq_hw", {31'b0, int_req}, 32'd1);
    rd("cause_ip2", 5'd13, 32'h0000_0400);
    hw_int = 6'b100001;
    step();
    rd("cause_ip7", 5'd13, 32'h0000_8400);
    hw_int = 6'b000001;
    wr(5'd12, 32'h0000_0001);
    chk("ireq_mask", {31'b0, int_req}, 32'd0);
    wr(5'd12, 32'h0000_0401);
    chk("ireq_on", {31'b0, int_req}, 32'd1);

    // exception entry from a delay slot
    exc_req = 1; exc_code = 5'd0;
    exc_pc = 32'h0000_1008; exc_bd = 1;
    step();
    idle();
    chk("exc_epc", epc_out, 32'h0000_1004);
    rd("exc_cause", 5'd13, 32'h8000_0400);
    chk("exc_exl", {31'b0, exl_out}, 32'd1);
    chk("exc_ireq", {31'b0, int_req}, 32'd0);

    // nested exception keeps EPC and BD
    exc_req = 1; exc_code = 5'd10;
    exc_pc = 32'h0000_2000; exc_bd = 0;
    step();
    idle();
    chk("nest_epc", epc_out, 32'h0000_1004);
    rd("nest_cause", 5'd13, 32'h8000_0428);

    eret = 1;
    step();
    idle();
    rd("eret_st", 5'd12, 32'h0000_0401);
    chk("eret_ireq", {31'b0, int_req}, 32'd1);
    chk("eret_epc", epc_out, 32'h0000_1004);

    // exc_req beats eret and we in one cycle
    exc_req = 1; eret = 1; we = 1;
    waddr = 5'd14; wdata = 32'hDEAD_BEEF;
    exc_code = 5'd8; exc_pc = 32'h0000_3000; exc_bd = 0;
    step();
    idle();
    chk("pri_epc", epc_out, 32'h0000_3000);
    chk("pri_exl", {31'b0, exl_out}, 32'd1);
    rd("pri_cause", 5'd13, 32'h0000_0420);
    eret = 1;
    step();
    idle();
    chk("eret2_exl", {31'b0, exl_out}, 32'd0);

    // eret beats we
    wr(5'd14, 32'h1234_5678);
    rd("epc_wr", 5'd14, 32'h1234_5678);
    eret = 1; we = 1; waddr = 5'd14; wdata = 32'hCAFE_F00D;
    step();
    idle();
    chk("eret_we", epc_out, 32'h1234_5678);

    // ERL clears before EXL
    hw_int = 0;
    wr(5'd12, 32'h0000_0407);
    eret = 1;
    step();
    idle();
    rd("erl_clr", 5'd12, 32'h0000_0403);
    chk("erl_exl", {31'b0, exl_out}, 32'd1);
    eret = 1;
    step();
    idle();
    rd("exl_clr", 5'd12, 32'h0000_0401);

    // PC wrap on delay-slot fault at address 0
    exc_req = 1; exc_code = 5'd12; exc_pc = 32'h0; exc_bd = 1;
    step();
    idle();
    chk("wrap_epc", epc_out, 32'hFFFF_FFFC);
    rd("wrap_cause", 5'd13, 32'h8000_0030);

    // asynchronous reset mid-cycle with exc_req high
    eret = 1;
    step();
    idle();
    exc_req = 1; exc_code = 5'd9; exc_pc = 32'h4000; exc_bd = 0;
    #2 rst = 1;
    #1;
    rd("arst_st", 5'd12, 32'h0000_FF01);
    rd("arst_cause", 5'd13, 32'h0);
    rd("arst_epc", 5'd14, 32'h0);
    chk("arst_exl", {31'b0, exl_out}, 32'd0);
    chk("arst_ireq", {31'b0, int_req}, 32'd0);
    step();
    rd("arst_hold", 5'd14, 32'h0);
    idle();
    rst = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cp0_status_cause.md
Name: cp0_status_cause

Overview:
- Parametrised successor to the single CP0 Status register.
- Holds the Status (reg 12), Cause (reg 13) and EPC (reg 14) registers in one block.
- Latches hardware interrupt lines into Cause.IP, raises a masked interrupt request, and sequences exception entry and ERET.
- Sits beside the pipeline's MEM/WB stage; the pipeline drives MTC0/MFC0 accesses and the exception and ERET strobes.

Parameters:
- NUM_HW_INT, 6, number of hardware interrupt lines (1..6), mapped to Cause.IP[2+NUM_HW_INT-1:2].
- RESET_BEV, 1'b0, Status.BEV value after reset.
- RESET_IM, 8'hFF, Status.IM value after reset.
- RESET_IE, 1'b1, Status.IE value after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- we  in  1  MTC0 write strobe.
- waddr  in  5  CP0 register number for the write.
- wdata  in  32  MTC0 write data.
- raddr  in  5  CP0 register number for the read.
- rdata  out  32  MFC0 read data; combinational from raddr.
- hw_int  in  NUM_HW_INT  hardware interrupt lines, synchronous to clk, level-sensitive.
- exc_req  in  1  exception-entry strobe, one cycle per exception.
- exc_code  in  5  ExcCode for this exception; 0 means interrupt.
- exc_pc  in  32  PC of the faulting instruction.
- exc_bd  in  1  faulting instruction is in a branch delay slot.
- eret  in  1  ERET commit strobe.
- int_req  out  1  pending, enabled and unmasked interrupt.
- epc_out  out  32  current EPC; used as the ERET target.
- exl_out  out  1  Status.EXL.
- bev_out  out  1  Status.BEV; selects the exception vector base.

Behaviour:
- Status layout: {9'b0, BEV, 6'b0, IM[7:0], 5'b0, ERL, EXL, IE}.
- Cause layout: {BD, 15'b0, IP[7:0], 1'b0, ExcCode[4:0], 2'b0}.
- Reset (asynchronous) values: BEV=RESET_BEV, IM=RESET_IM, ERL=0, EXL=0, IE=RESET_IE; Cause=0; EPC=0. int_req=0 immediately on reset.
- Per-cycle update priority: rst > exc_req > eret > we.
  - exc_req suppresses any same-cycle eret and any we, to every register.
  - eret suppresses any same-cycle we.
- MTC0 writes:
  - waddr=12: BEV, IM, ERL, EXL, IE take wdata[22], wdata[15:8], wdata[2], wdata[1], wdata[0].
  - waddr=13: only IP[1:0] (software interrupts) take wdata[9:8]; all other Cause bits are read-only.
  - waddr=14: EPC=wdata.
  - Any other waddr: write ignored.
- Reads: rdata returns the current register value for raddr 12, 13 or 14, else 0. Same-cycle write is not forwarded; the new value is readable the cycle after.
- Hardware interrupt pending:
  - Every cycle IP[2+i] <= hw_int[i]; 1-cycle latency.
  - IP bits at or above 2+NUM_HW_INT are constant 0.
  - Writes never affect the hardware IP bits.
- Interrupt request: int_req = IE & ~EXL & ~ERL & |(IP & IM), combinational from registers.
  - hw_int rising at edge n gives int_req high after edge n+1 when enabled.
- Exception entry (exc_req=1):
  - If EXL==0: EPC <= exc_bd ? exc_pc-32'd4 : exc_pc, and BD <= exc_bd.
  - If EXL==1 (nested): EPC and BD are unchanged.
  - Always: EXL <= 1, ExcCode <= exc_code.
  - int_req deasserts the cycle after entry.
- ERET (eret=1, exc_req=0): if ERL==1 then ERL <= 0, else EXL <= 0. EPC is unchanged.
- Fixed-value outputs: exl_out=EXL, bev_out=BEV, epc_out=EPC.
- PC arithmetic wraps modulo 2^32: exc_pc=0 with exc_bd=1 gives EPC=32'hFFFF_FFFC.
- Reset asserted mid-operation (e.g. exc_req high) overrides everything.

Decomposition:
- Package cp0_pkg holds:
  - register numbers CP0_STATUS=12, CP0_CAUSE=13, CP0_EPC=14;
  - bit-position constants for BEV, IM, ERL, EXL, IE, BD, IP and ExcCode;
  - ExcCode constants: INT=0, SYS=8, BP=9, RI=10, OV=12.
- Sub-module cp0_int_pending (parameter NUM_HW_INT): holds the IP register and produces int_req from IP, IM, IE, EXL and ERL.

Test Plan:
- Reset with clk held: rdata for raddr=12 reads 32'h0000_FF01; int_req=0; Cause=0; EPC=0.
- Write 32'h0040_0403 to reg 12 -> next cycle Status reads 32'h0040_0403, bev_out=1, exl_out=1; write to reg 13 with 32'hFFFF_FFFF -> Cause reads 32'h0000_0300 only.
- IE=1, EXL=0, IM=8'h04, hw_int[0]=1 at edge n -> IP[2]=1 and int_req=1 after edge n+1; IM=8'h00 -> int_req=0.
- exc_req with code 0, exc_pc=32'h0000_1008, exc_bd=1 -> EPC=32'h0000_1004, BD=1, EXL=1, int_req=0. A second exc_req with code 10, exc_pc=32'h2000 -> EPC unchanged, ExcCode=10.
- exc_req, eret and we to reg 14 (wdata=32'hDEAD_BEEF) in the same cycle -> exception result only: EXL=1, EPC from exc_pc. ERET alone afterwards -> EXL=0.
- ERL=1 and EXL=1, then eret -> ERL=0 and EXL stays 1; rst asserted mid-cycle with exc_req high -> all registers at reset values immediately.
